// File: rtl/param_updown_timer.sv
// Up/down interval timer with preset register, auto-reload or one-shot, registered expiry pulse.
// Optional saturating expiry counter (expire_cnt) is built when UPDN_EXPIRE_CNT_EN is defined.
module param_updown_timer #(
    parameter int WIDTH = 8,
    parameter int EXP_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             preset_load,
    input  logic [WIDTH-1:0] preset_value,
    input  logic             enable_cnt_up,
    input  logic             enable_cnt_dn,
    input  logic             pause_counting,
    input  logic             one_shot,
    output logic [WIDTH-1:0] count_value,
    output logic             ctr_expired,
    output logic             cnt_done
`ifdef UPDN_EXPIRE_CNT_EN
    ,
    output logic [EXP_W-1:0] expire_cnt
`endif
);

    logic [WIDTH-1:0] preset_q;
    logic [WIDTH-1:0] count_q, count_d;
    logic             done_q, done_d;
    logic             expired_q, expired_d;
    logic             dir_up_d1_q, dir_dn_d1_q;

    logic [WIDTH-1:0] pre_eff;
    logic             dir_up, dir_dn;
    logic             up_rise, dn_rise;
    logic             terminal;

    // A preset written this cycle is already the one in force.
    assign pre_eff = preset_load ? preset_value : preset_q;

    assign dir_up  = enable_cnt_up & ~enable_cnt_dn;
    assign dir_dn  = enable_cnt_dn & ~enable_cnt_up;
    assign up_rise = dir_up & ~dir_up_d1_q;
    assign dn_rise = dir_dn & ~dir_dn_d1_q;

    // Up uses >= so a preset lowered below the count ends the period instead of wrapping.
    assign terminal = dir_up ? (count_q >= pre_eff) : (count_q == '0);

    always_comb begin
        count_d   = count_q;
        done_d    = done_q;
        expired_d = 1'b0;
        if (dn_rise) begin
            count_d = pre_eff;
            done_d  = 1'b0;
        end else if (up_rise) begin
            count_d = '0;
            done_d  = 1'b0;
        end else if (!(dir_up || dir_dn) || pause_counting || done_q) begin
            count_d = count_q;
        end else if (terminal) begin
            expired_d = 1'b1;
            if (one_shot) begin
                done_d = 1'b1;
            end else begin
                count_d = dir_up ? '0 : pre_eff;
            end
        end else begin
            count_d = dir_up ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            preset_q    <= '0;
            count_q     <= '0;
            done_q      <= 1'b0;
            expired_q   <= 1'b0;
            dir_up_d1_q <= 1'b0;
            dir_dn_d1_q <= 1'b0;
        end else begin
            if (preset_load) begin
                preset_q <= preset_value;
            end
            count_q     <= count_d;
            done_q      <= done_d;
            expired_q   <= expired_d;
            dir_up_d1_q <= dir_up;
            dir_dn_d1_q <= dir_dn;
        end
    end

    assign count_value = count_q;
    assign ctr_expired = expired_q;
    assign cnt_done    = done_q;

`ifdef UPDN_EXPIRE_CNT_EN
    logic [EXP_W-1:0] expire_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            expire_cnt_q <= '0;
        end else if (expired_d && (expire_cnt_q != {EXP_W{1'b1}})) begin
            expire_cnt_q <= expire_cnt_q + EXP_W'(1);
        end
    end

    assign expire_cnt = expire_cnt_q;
`endif

endmodule

// File: tb/tb_param_updown_timer.sv
// Randomised and directed bench for param_updown_timer against a cycle-level behavioural model.
module tb_param_updown_timer;

    localparam int WIDTH = 8;
    localparam int EXP_W = 2;
    localparam int MODV  = 1 << WIDTH;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             preset_load = 1'b0;
    logic [WIDTH-1:0] preset_value = '0;
    logic             enable_cnt_up = 1'b0;
    logic             enable_cnt_dn = 1'b0;
    logic             pause_counting = 1'b0;
    logic             one_shot = 1'b0;
    logic [WIDTH-1:0] count_value;
    logic             ctr_expired;
    logic             cnt_done;
`ifdef UPDN_EXPIRE_CNT_EN
    logic [EXP_W-1:0] expire_cnt;
`endif

    param_updown_timer #(.WIDTH(WIDTH), .EXP_W(EXP_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .preset_load    (preset_load),
        .preset_value   (preset_value),
        .enable_cnt_up  (enable_cnt_up),
        .enable_cnt_dn  (enable_cnt_dn),
        .pause_counting (pause_counting),
        .one_shot       (one_shot),
        .count_value    (count_value),
        .ctr_expired    (ctr_expired),
        .cnt_done       (cnt_done)
`ifdef UPDN_EXPIRE_CNT_EN
        ,
        .expire_cnt     (expire_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Behavioural reference state
    int m_count = 0, m_preset = 0, m_expcnt = 0;
    bit m_done = 0, m_exp = 0, m_up_prev = 0, m_dn_prev = 0;

    task automatic check_val(input string tag, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s @cycle %0d: got=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    task automatic model_step();
        int  pe;
        bit  up, dn, active;
        if (reset) begin
            m_count = 0; m_preset = 0; m_expcnt = 0;
            m_done = 0; m_exp = 0; m_up_prev = 0; m_dn_prev = 0;
            return;
        end
        pe = preset_load ? int'(preset_value) : m_preset;
        up = enable_cnt_up && !enable_cnt_dn;
        dn = enable_cnt_dn && !enable_cnt_up;
        m_exp = 0;
        if (dn && !m_dn_prev) begin
            m_count = pe; m_done = 0;
        end else if (up && !m_up_prev) begin
            m_count = 0; m_done = 0;
        end else begin
            active = (up || dn) && !pause_counting && !m_done;
            if (active) begin
                if ((up && m_count >= pe) || (dn && m_count == 0)) begin
                    m_exp = 1;
                    if (m_expcnt < (1 << EXP_W) - 1) m_expcnt++;
                    if (one_shot) m_done = 1;
                    else m_count = up ? 0 : pe;
                end else begin
                    m_count = up ? (m_count + 1) % MODV : (m_count + MODV - 1) % MODV;
                end
            end
        end
        if (preset_load) m_preset = int'(preset_value);
        m_up_prev = up;
        m_dn_prev = dn;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        check_val("count", count_value, m_count);
        check_val("expired", ctr_expired, m_exp);
        check_val("done", cnt_done, m_done);
`ifdef UPDN_EXPIRE_CNT_EN
        check_val("expire_cnt", expire_cnt, m_expcnt);
`endif
    endtask

    task automatic load_preset(input int v);
        preset_load = 1'b1;
        preset_value = WIDTH'(v);
        tick();
        preset_load = 1'b0;
    endtask

    task automatic wait_model_count(input string tag, input int target, input int budget);
        int n = 0;
        while (m_count != target && n < budget) begin
            tick();
            n++;
        end
        if (m_count != target) check_val(tag, m_count, target);
    endtask

    initial begin
        int last_pulse, pulses, n;

        // Reset with a direction held: first cycle after reset must be a rising edge
        enable_cnt_dn = 1'b1;
        tick();
        tick();
        check_val("reset_count", count_value, 0);
        check_val("reset_exp", ctr_expired, 0);
        check_val("reset_done", cnt_done, 0);
        enable_cnt_dn = 1'b0;
        reset = 1'b0;
        tick();
        $display("txn reset: count=%0d", count_value);

        // Auto-reload down, preset 5
        load_preset(5);
        enable_cnt_dn = 1'b1;
        tick();
        check_val("dn_load", count_value, 5);
        last_pulse = -1;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (ctr_expired) begin
                check_val("dn_pulse_val", count_value, 5);
                if (last_pulse >= 0) check_val("dn_period", cyc - last_pulse, 6);
                last_pulse = cyc;
            end
        end
        $display("txn autoreload_down: last_pulse=%0d", last_pulse);

        // One-shot up, preset 3
        enable_cnt_dn = 1'b0;
        enable_cnt_up = 1'b1;
        one_shot = 1'b1;
        load_preset(3);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ctr_expired) pulses++;
        end
        check_val("os_pulses", pulses, 1);
        check_val("os_hold", count_value, 3);
        check_val("os_done", cnt_done, 1);
        enable_cnt_up = 1'b0;
        tick();
        check_val("os_drop_done", cnt_done, 1);
        enable_cnt_up = 1'b1;
        tick();
        check_val("os_restart_cnt", count_value, 0);
        check_val("os_restart_done", cnt_done, 0);
        $display("txn oneshot_up: pulses=%0d", pulses);

        // Pause in down mode, preset 4
        one_shot = 1'b0;
        enable_cnt_up = 1'b0;
        enable_cnt_dn = 1'b1;
        load_preset(4);
        wait_model_count("pause_wait", 2, 20);
        pause_counting = 1'b1;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n++;
            check_val("pause_hold", count_value, 2);
        end
        pause_counting = 1'b0;
        while (!ctr_expired && n < 20) begin
            tick();
            n++;
        end
        check_val("pause_delay", n, 6);
        $display("txn pause: pulse_after=%0d", n);

        // Both enables high: idle
        enable_cnt_up = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        enable_cnt_up = 1'b0;
        tick();

        // Swap up->down at count 7, preset 9
        enable_cnt_dn = 1'b0;
        enable_cnt_up = 1'b1;
        load_preset(9);
        wait_model_count("swap_wait", 7, 30);
        enable_cnt_up = 1'b0;
        enable_cnt_dn = 1'b1;
        tick();
        check_val("swap_load", count_value, 9);
        $display("txn swap: count=%0d", count_value);

        // Preset load coincident with dn_rise
        enable_cnt_dn = 1'b0;
        tick();
        enable_cnt_dn = 1'b1;
        preset_load = 1'b1;
        preset_value = 8'd2;
        tick();
        preset_load = 1'b0;
        check_val("load_with_rise", count_value, 2);

        // Preset 0 in both modes
        load_preset(0);
        enable_cnt_dn = 1'b0;
        tick();
        enable_cnt_dn = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("p0_dn_pulse", ctr_expired, 1);
        end
        enable_cnt_dn = 1'b0;
        enable_cnt_up = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("p0_up_pulse", ctr_expired, 1);
        end
        $display("txn preset0: done");

        // Up mode, preset lowered from 200 to 10 at count 50
        load_preset(200);
        enable_cnt_up = 1'b0;
        tick();
        enable_cnt_up = 1'b1;
        wait_model_count("lower_wait", 50, 80);
        load_preset(10);
        check_val("lower_pulse", ctr_expired, 1);
        check_val("lower_count", count_value, 0);
        $display("txn preset_lower: count=%0d", count_value);

        // Reset mid-count
        for (int i = 0; i < 3; i++) tick();
        reset = 1'b1;
        tick();
        check_val("rst_mid_count", count_value, 0);
        check_val("rst_mid_exp", ctr_expired, 0);
        check_val("rst_mid_done", cnt_done, 0);
        reset = 1'b0;
        enable_cnt_up = 1'b0;
        tick();

`ifdef UPDN_EXPIRE_CNT_EN
        // Five expiries saturate a 2-bit counter at 3
        load_preset(0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        preset_value = 8'd0;
        enable_cnt_dn = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check_val("expcnt_sat", expire_cnt, 3);
        enable_cnt_dn = 1'b0;
        reset = 1'b1;
        tick();
        check_val("expcnt_rst", expire_cnt, 0);
        reset = 1'b0;
        $display("txn expire_cnt: saturated and cleared");
`endif

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            preset_load = ($urandom_range(0, 15) == 0);
            preset_value = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 12));
            if ($urandom_range(0, 19) == 0) enable_cnt_up = ~enable_cnt_up;
            if ($urandom_range(0, 19) == 0) enable_cnt_dn = ~enable_cnt_dn;
            pause_counting = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 49) == 0) one_shot = ~one_shot;
            reset = ($urandom_range(0, 199) == 0);
            tick();
        end
        $display("txn random: cycles=%0d", cyc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/param_updown_timer.md
# param_updown_timer

Parametrised up/down interval counter with registered terminal detection, auto-reload or one-shot mode, and a preset register loadable at any time. It is the general-purpose event timer for control blocks in the counter library: its period is set by a preset, and `ctr_expired` pulses once per completed period.

## Interface
- `WIDTH`, default 8: width of the count and preset, in bits (≥2).
- `EXP_W`, default 8: width of `expire_cnt`; used only when `UPDN_EXPIRE_CNT_EN` is defined.
- `clk`  in  1  clock; all logic is on the rising edge.
- `reset`  in  1  synchronous reset, active-high.
- `preset_load`  in  1  captures `preset_value` into the preset register.
- `preset_value`  in  WIDTH  new preset.
- `enable_cnt_up`  in  1  count-up request (level).
- `enable_cnt_dn`  in  1  count-down request (level).
- `pause_counting`  in  1  freezes the count and suppresses expiry.
- `one_shot`  in  1  1 = stop at terminal, 0 = auto-reload.
- `count_value`  out  WIDTH  current count, registered.
- `ctr_expired`  out  1  one-cycle pulse per terminal event, registered.
- `cnt_done`  out  1  level; the one-shot run has finished.
- `expire_cnt`  out  EXP_W  saturating count of expiries (macro only).

## Operation
- **Effective preset:** `pre_eff = preset_load ? preset_value : preset_q`. `preset_q` is updated whenever `preset_load` is 1.
- **Direction decode:**
  - `dir_up = enable_cnt_up & ~enable_cnt_dn`.
  - `dir_dn = enable_cnt_dn & ~enable_cnt_up`.
  - Both requests high is treated as idle.
- **Edge detection:** registers `dir_up_d1` and `dir_dn_d1` (reset 0).
  - `up_rise = dir_up & ~dir_up_d1`.
  - `dn_rise = dir_dn & ~dir_dn_d1`.
- **Terminal condition:**
  - Up: `count >= pre_eff`. Using ≥ means a preset lowered mid-run ends the period on the next active cycle; the count never wraps.
  - Down: `count == 0`.
- **Next-state priority, first match wins:**
  1. `dn_rise`: count ← `pre_eff`, done ← 0.
  2. `up_rise`: count ← 0, done ← 0.
  3. No direction active, or `pause_counting`, or done = 1: hold.
  4. Terminal reached: `ctr_expired` ← 1.
     - If `one_shot` = 0: reload (up → 0, down → `pre_eff`).
     - If `one_shot` = 1: hold the count and set done ← 1.
  5. Otherwise: count ± 1.
- **Step 5 arithmetic:** modulo 2^WIDTH. Wrap is unreachable in normal use.
- **Expiry pulse:** `ctr_expired` is 0 in every cycle where step 4 was not taken.
- **`cnt_done`:**
  - Cleared only by a direction rising edge or by reset.
  - Dropping the direction keeps both `cnt_done` and the count.
- **Direct direction swap:** a swap in one cycle (up falls, down rises) is a `dn_rise` and reloads `pre_eff`. The same applies in reverse.
- **Preset 0:** both modes expire on every active cycle. The period is `pre_eff` + 1 active cycles in both modes.
- **Preset changes mid-run:**
  - Down mode uses the new preset at the next reload.
  - Up mode compares against it immediately.

## Timing
- **Reset values:** on reset, `count_value`, `ctr_expired`, `cnt_done`, `expire_cnt`, `preset_q` and the d1 registers all become 0. Reset overrides every input in the same edge.
- **Direction request held through reset:** the first cycle after reset is a rising edge.
- **Load latency:** when `dn_rise` is sampled at edge k, `count_value` equals `pre_eff` after edge k. The first decrement happens at edge k+1.
- **Expiry latency:**
  - `ctr_expired` is high for the single cycle after the edge that took step 4.
  - In that same cycle, `count_value` already shows the reloaded value (or the held value in one-shot mode).
- **Period:** in auto-reload mode with no pauses, pulses are exactly `pre_eff` + 1 cycles apart.
- **Pause:** a pause of N cycles delays the next pulse by exactly N cycles. Edge registers keep tracking during a pause.
- **Reset mid-run:** the count is lost and the pulse is suppressed. If a direction is still high after reset, counting restarts as a fresh rising edge.

## Configuration
- **Macro:** `UPDN_EXPIRE_CNT_EN`.
- **Defined:**
  - Port `expire_cnt[EXP_W-1:0]` exists.
  - It increments on every edge that takes step 4 and saturates at 2^EXP_W − 1.
  - It is cleared only by reset.
- **Not defined:**
  - The port and its register are absent.
  - All other behaviour is identical.

## Test plan
- **Auto-reload down:** with WIDTH=8, load preset 5, then hold `enable_cnt_dn`. Required: `count_value` steps 5,4,3,2,1,0,5…, `ctr_expired` pulses every 6 cycles, and each pulse coincides with `count_value` = 5.
- **One-shot up:** load preset 3, set `one_shot`=1, hold `enable_cnt_up`. Required: the count goes 0,1,2,3 and then holds at 3; exactly one pulse; `cnt_done`=1. Dropping and re-raising `enable_cnt_up` restarts from 0 with `cnt_done`=0.
- **Pause:** down mode, preset 4, assert `pause_counting` for 3 cycles at count 2. Required: the count holds at 2 and the next pulse arrives 3 cycles late.
- **Simultaneous and swap events:**
  - Both enables high: the count holds with no pulse.
  - Swap up→down at count 7 with preset 9: the count goes to 9 on the next edge.
  - `preset_load`=1 with value 2 in the same cycle as `dn_rise`: the count loads 2.
- **Boundaries:**
  - Preset 0 in either mode: a pulse on every active cycle.
  - Up mode with preset lowered from 200 to 10 at count 50: a pulse on the next active cycle, then the count is 0.
  - Reset mid-count: all outputs are 0 on the following cycle.
- **With `UPDN_EXPIRE_CNT_EN`, EXP_W=2:** 5 expiries leave `expire_cnt` = 3 (saturated); reset clears it to 0.
